// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, opcode constants,
// opcode/target field positions and the fetch FSM state type.
package fetch_pkg;

  localparam int unsigned PC_W    = 4;
  localparam int unsigned OP_W    = 32;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned TGT_LSB = 0;

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: redirect, local jump (PC_FETCH_JUMP_PREDECODE_EN),
// halt hold, otherwise sequential increment modulo 2^PC_W.
module pc_next #(
  parameter int unsigned PC_W = fetch_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [3:0]      opcode,
  input  logic [PC_W-1:0] jmp_tgt,
  input  logic            redir_en,
  input  logic [PC_W-1:0] redir_pc,
  output logic [PC_W-1:0] next_pc
);
  import fetch_pkg::*;

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (redir_en) begin
      next_pc = redir_pc;
`ifdef PC_FETCH_JUMP_PREDECODE_EN
    end else if (opcode == OP_JMP) begin
      next_pc = jmp_tgt;
`endif
    end else if (opcode == OP_HALT) begin
      next_pc = pc;
    end
  end

`ifndef PC_FETCH_JUMP_PREDECODE_EN
  logic unused_jmp;
  assign unused_jmp = ^jmp_tgt;
`endif

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC, instruction register with valid/ready handoff,
// redirect/halt handling and saturating fetch counter. Optional: PC_FETCH_JUMP_PREDECODE_EN.
module pc_fetch #(
  parameter int unsigned PC_W = fetch_pkg::PC_W,
  parameter int unsigned OP_W = fetch_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] pc_out,
  input  logic [OP_W-1:0] op,
  output logic [OP_W-1:0] ir_op,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  output logic            halted,
  output logic [7:0]      fetch_count
);
  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc;
  logic [OP_W-1:0] ir_op_q, ir_op_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      opcode;
  logic            redir_en, load;

  assign opcode   = op[OPC_MSB:OPC_LSB];
  assign redir_en = (state_q == ST_FETCH) && redir_valid;
  assign load     = (state_q == ST_FETCH) && (!ir_valid_q || ir_ready);

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc       (pc_q),
    .opcode   (opcode),
    .jmp_tgt  (op[TGT_LSB +: PC_W]),
    .redir_en (redir_en),
    .redir_pc (redir_pc),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_op_d    = ir_op_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
      end
      ST_FETCH: begin
        // Redirect flushes IR even when a transfer coincides with it.
        if (redir_valid) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
        end else if (load) begin
          ir_op_d    = op;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = next_pc;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (opcode == OP_HALT) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_op_q    <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_op_q    <= ir_op_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign ir_op       = ir_op_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboarded directed bench for pc_fetch; expected IR transfers are queued by
// the stimulus and checked by an independent monitor on each valid/ready handshake.
module tb_pc_fetch;

  localparam logic [3:0] PC_AFTER_JMP =
`ifdef PC_FETCH_JUMP_PREDECODE_EN
    4'd1;
`else
    4'd3;
`endif

  logic        clk = 1'b0;
  logic        rst_n, run, ir_ready, redir_valid, ir_valid, halted;
  logic [3:0]  pc_out, ir_pc, redir_pc;
  logic [31:0] op, ir_op;
  logic [7:0]  fetch_count;
  logic [31:0] mem [16];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned pops  = 0;

  typedef struct packed {
    logic [3:0]  pc;
    logic [31:0] op;
  } xfer_t;
  xfer_t exp_q [$];

  always #5 clk = ~clk;

  assign op = mem[pc_out];

  pc_fetch #(.PC_W(4), .OP_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .pc_out      (pc_out),
    .op          (op),
    .ir_op       (ir_op),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] pc, input logic [31:0] o);
    xfer_t x;
    x.pc = pc;
    x.op = o;
    exp_q.push_back(x);
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [3:0] pc,
                           input logic [3:0] ipc, input logic [7:0] cnt, input logic h);
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(v));
    chk({tag, ".pc_out"}, 32'(pc_out), 32'(pc));
    chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(ipc));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(cnt));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1) begin
      xfer_t x;
      pops++;
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_xfer_pc", 32'(ir_pc), 32'hFFFF_FFFF);
      end else begin
        x = exp_q.pop_front();
        chk("sb.ir_pc", 32'(ir_pc), 32'(x.pc));
        chk("sb.ir_op", ir_op, x.op);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0]  = 32'h0010_0000;
    mem[1]  = 32'h0110_0000;
    mem[2]  = 32'h1000_0001;
    mem[3]  = 32'h4000_0003;
    mem[9]  = 32'h2000_0009;
    mem[15] = 32'h3000_000F;

    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    cyc(); cyc();
    chk_state("reset", 1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
    chk("reset.ir_op", ir_op, 32'h0);

    rst_n = 1'b1;
    cyc();
    chk_state("idle", 1'b0, 4'd0, 4'd0, 8'd0, 1'b0);

    push(4'd0, 32'h0010_0000);
    push(4'd1, 32'h0110_0000);
    push(4'd2, 32'h1000_0001);
    run = 1'b1; ir_ready = 1'b1;
    cyc();
    run = 1'b0;
    chk_state("start", 1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
    cyc();
    chk_state("load0", 1'b1, 4'd1, 4'd0, 8'd1, 1'b0);
    cyc();
    chk_state("load1", 1'b1, 4'd2, 4'd1, 8'd2, 1'b0);
    cyc();
    chk_state("load_jmp", 1'b1, PC_AFTER_JMP, 4'd2, 8'd3, 1'b0);

    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_state("stall", 1'b1, PC_AFTER_JMP, 4'd2, 8'd3, 1'b0);
      chk("stall.ir_op", ir_op, 32'h1000_0001);
    end

    ir_ready = 1'b1;
    cyc();
    chk_state("release", 1'b1, PC_AFTER_JMP + 4'd1, PC_AFTER_JMP, 8'd4, 1'b0);

    redir_valid = 1'b1; redir_pc = 4'h9; ir_ready = 1'b0;
    cyc();
    chk_state("redir9", 1'b0, 4'd9, PC_AFTER_JMP, 8'd4, 1'b0);

    redir_valid = 1'b0; ir_ready = 1'b1;
    push(4'd9, 32'h2000_0009);
    cyc();
    chk_state("load9", 1'b1, 4'd10, 4'd9, 8'd5, 1'b0);

    redir_valid = 1'b1; redir_pc = 4'hF;
    cyc();
    chk_state("redir15", 1'b0, 4'd15, 4'd9, 8'd5, 1'b0);

    redir_valid = 1'b0;
    push(4'd15, 32'h3000_000F);
    cyc();
    chk_state("wrap", 1'b1, 4'd0, 4'd15, 8'd6, 1'b0);

    mem[3] = 32'hF000_0003;
    redir_valid = 1'b1; redir_pc = 4'h3;
    cyc();
    chk_state("redir3", 1'b0, 4'd3, 4'd15, 8'd6, 1'b0);

    redir_valid = 1'b0; ir_ready = 1'b0;
    push(4'd3, 32'hF000_0003);
    cyc();
    chk_state("halt_load", 1'b1, 4'd3, 4'd3, 8'd7, 1'b1);

    redir_valid = 1'b1; redir_pc = 4'h7;
    cyc(); cyc();
    chk_state("halt_hold", 1'b1, 4'd3, 4'd3, 8'd7, 1'b1);

    ir_ready = 1'b1;
    cyc();
    chk_state("halt_drain", 1'b0, 4'd3, 4'd3, 8'd7, 1'b1);

    redir_valid = 1'b0; run = 1'b1;
    cyc(); cyc();
    chk_state("halt_stay", 1'b0, 4'd3, 4'd3, 8'd7, 1'b1);

    rst_n = 1'b0;
    cyc();
    chk_state("rerst", 1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
    chk("rerst.ir_op", ir_op, 32'h0);
    rst_n = 1'b1; run = 1'b0; ir_ready = 1'b0;
    cyc();
    chk_state("re_idle", 1'b0, 4'd0, 4'd0, 8'd0, 1'b0);

    chk("sb.remaining", 32'(exp_q.size()), 32'd0);
    chk("sb.transfers", 32'(pops), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
